// File: rtl/fsm_moore_seq_counter_if.sv
// Button/LED bundle for fsm_moore_seq_counter: board-side buttons in, LED bank and status out.
interface fsm_moore_seq_counter_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 go_btn;
    logic                 pause_btn;
    logic                 dir;
    logic [CNT_WIDTH-1:0] led;
    logic                 done_sig;
    logic                 busy;

    modport master (
        output go_btn,
        output pause_btn,
        output dir,
        input  led,
        input  done_sig,
        input  busy
    );

    modport slave (
        input  go_btn,
        input  pause_btn,
        input  dir,
        output led,
        output done_sig,
        output busy
    );
endinterface

// File: rtl/fsm_moore_seq_counter.sv
// Tick-paced Moore up/down LED counter running N_LOOPS passes with pause/resume.
// Optional macro FSM_AUTO_RESTART_EN: a go seen in DONE restarts the run without passing IDLE.
module fsm_moore_seq_counter #(
    parameter int CLK_DIV   = 2000000,
    parameter int CNT_WIDTH = 4,
    parameter int MAX_COUNT = 15,
    parameter int N_LOOPS   = 1
) (
    input  logic                    clk,
    input  logic                    rst_btn,
    fsm_moore_seq_counter_if.slave  bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LOOP_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
    localparam logic [LOOP_W-1:0]    LOOP_LAST = LOOP_W'(N_LOOPS - 1);
    localparam logic [LOOP_W-1:0]    LOOP_ZERO = {LOOP_W{1'b0}};
    localparam logic [LOOP_W-1:0]    LOOP_ONE  = LOOP_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNTING = 2'd1,
        S_PAUSED   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    logic [1:0]           go_sync_r;
    logic [1:0]           pause_sync_r;
    logic [DIV_W-1:0]     div_r;
    state_t               state_r;
    logic [CNT_WIDTH-1:0] led_r;
    logic [LOOP_W-1:0]    loop_r;
    logic                 dir_r;
    logic                 done_r;
    logic                 busy_r;

    logic                 go_s;
    logic                 pause_s;
    logic                 tick_s;
    state_t               state_s;
    logic [CNT_WIDTH-1:0] led_s;
    logic [LOOP_W-1:0]    loop_s;
    logic                 dir_s;
    logic [CNT_WIDTH-1:0] start_s;
    logic [CNT_WIDTH-1:0] term_s;
    logic [CNT_WIDTH-1:0] start_new_s;

    // Two-flop synchronisers for the inverted (active-high) button requests.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            go_sync_r    <= 2'b00;
            pause_sync_r <= 2'b00;
        end else begin
            go_sync_r    <= {go_sync_r[0], ~bus.go_btn};
            pause_sync_r <= {pause_sync_r[0], ~bus.pause_btn};
        end
    end

    assign go_s    = go_sync_r[1];
    assign pause_s = pause_sync_r[1];

    // Free-running tick divider; tick is a clk-domain enable, never a clock.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            div_r <= DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    assign tick_s = (div_r == DIV_LAST);

    // Start/terminal values for the latched direction, and start value for a fresh latch.
    always_comb begin
        start_s     = CNT_ZERO;
        term_s      = CNT_MAX;
        start_new_s = CNT_ZERO;
        if (dir_r) begin
            start_s = CNT_MAX;
            term_s  = CNT_ZERO;
        end else begin
            start_s = CNT_ZERO;
            term_s  = CNT_MAX;
        end
        if (bus.dir) begin
            start_new_s = CNT_MAX;
        end else begin
            start_new_s = CNT_ZERO;
        end
    end

    // Next-state and next-count logic; pause outranks the terminal check, which outranks the step.
    always_comb begin
        state_s = state_r;
        led_s   = led_r;
        loop_s  = loop_r;
        dir_s   = dir_r;
        case (state_r)
            S_IDLE: begin
                led_s = CNT_ZERO;
                if (go_s) begin
                    dir_s   = bus.dir;
                    led_s   = start_new_s;
                    loop_s  = LOOP_ZERO;
                    state_s = S_COUNTING;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_COUNTING: begin
                if (pause_s) begin
                    state_s = S_PAUSED;
                end else if ((led_r == term_s) && (loop_r == LOOP_LAST)) begin
                    state_s = S_DONE;
                    led_s   = CNT_ZERO;
                end else if (led_r == term_s) begin
                    led_s  = start_s;
                    loop_s = loop_r + LOOP_ONE;
                end else if (dir_r) begin
                    led_s = led_r - CNT_ONE;
                end else begin
                    led_s = led_r + CNT_ONE;
                end
            end
            S_PAUSED: begin
                if (pause_s) begin
                    state_s = S_PAUSED;
                end else begin
                    state_s = S_COUNTING;
                end
            end
            S_DONE: begin
`ifdef FSM_AUTO_RESTART_EN
                if (go_s) begin
                    dir_s   = bus.dir;
                    led_s   = start_new_s;
                    loop_s  = LOOP_ZERO;
                    state_s = S_COUNTING;
                end else begin
                    led_s   = CNT_ZERO;
                    state_s = S_IDLE;
                end
`else
                led_s   = CNT_ZERO;
                state_s = S_IDLE;
`endif
            end
            default: begin
                state_s = S_IDLE;
                led_s   = CNT_ZERO;
                loop_s  = LOOP_ZERO;
            end
        endcase
    end

    // State, count and Moore flags advance together, only on tick edges.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_r <= S_IDLE;
            led_r   <= CNT_ZERO;
            loop_r  <= LOOP_ZERO;
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else if (tick_s) begin
            state_r <= state_s;
            led_r   <= led_s;
            loop_r  <= loop_s;
            dir_r   <= dir_s;
            done_r  <= (state_s == S_DONE);
            busy_r  <= (state_s == S_COUNTING) || (state_s == S_PAUSED);
        end
    end

    assign bus.led      = led_r;
    assign bus.done_sig = done_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_fsm_moore_seq_counter.sv
// Scoreboard bench for fsm_moore_seq_counter: two instances (1 and 2 loops) with a fast tick.
module tb_fsm_moore_seq_counter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_btn = 1'b1;
    int   cyc;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [3:0] led;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    fsm_moore_seq_counter_if #(.CNT_WIDTH(4)) a_if ();
    fsm_moore_seq_counter_if #(.CNT_WIDTH(4)) b_if ();

    fsm_moore_seq_counter #(.CLK_DIV(DIV), .CNT_WIDTH(4), .MAX_COUNT(15), .N_LOOPS(1)) dut_a (
        .clk(clk), .rst_btn(rst_btn), .bus(a_if.slave)
    );
    fsm_moore_seq_counter #(.CLK_DIV(DIV), .CNT_WIDTH(4), .MAX_COUNT(15), .N_LOOPS(2)) dut_b (
        .clk(clk), .rst_btn(rst_btn), .bus(b_if.slave)
    );

    always #5 clk = ~clk;

    // Bench-side count of clk edges since reset release, for tick alignment.
    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input int led, input bit done, input bit busy);
        exp_t x;
        x.led  = 4'(led);
        x.done = done;
        x.busy = busy;
        exp_q.push_back(x);
    endfunction

    // Wait to the negedge following the next tick edge.
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((cyc % DIV) != 0) && (n < 4 * DIV));
        if (n >= 4 * DIV) begin
            checks++;
            failures++;
            $display("FAIL tick_align waited=%0d clk, required tick within %0d", n, DIV);
        end
    endtask

    task automatic run_tick(input bit sel, input bit go, input bit pause);
        if (sel) begin
            b_if.go_btn    = ~go;
            b_if.pause_btn = ~pause;
        end else begin
            a_if.go_btn    = ~go;
            a_if.pause_btn = ~pause;
        end
        next_tick();
    endtask

    task automatic apply_reset();
        a_if.go_btn = 1'b1; a_if.pause_btn = 1'b1;
        b_if.go_btn = 1'b1; b_if.pause_btn = 1'b1;
        rst_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        a_if.go_btn = 1'b1; a_if.pause_btn = 1'b1; a_if.dir = 1'b0;
        b_if.go_btn = 1'b1; b_if.pause_btn = 1'b1; b_if.dir = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_btn = 1'b0;
        #1;
        checks++;
        if (a_if.led !== 4'd0 || a_if.done_sig !== 1'b0 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_immediate led=%0d done=%b busy=%b required 0/0/0", a_if.led, a_if.done_sig, a_if.busy);
        end
        for (int i = 0; i < 10; i++) begin
            a_if.go_btn = i[0];
            @(negedge clk);
            checks++;
            if (a_if.led !== 4'd0 || a_if.done_sig !== 1'b0 || a_if.busy !== 1'b0 ||
                b_if.led !== 4'd0 || b_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold clk=%0d led=%0d done=%b busy=%b required 0/0/0", i, a_if.led, a_if.done_sig, a_if.busy);
            end
        end
        a_if.go_btn = 1'b1;
        rst_btn = 1'b1;
    endtask

    task automatic test_up_run();
        apply_reset();
        a_if.dir = 1'b0;
        for (int v = 0; v <= 15; v++) push_exp(v, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, t == 1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.done_sig !== e.done || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL up_run tick=%0d got led=%0d done=%b busy=%b required led=%0d done=%b busy=%b",
                         t, a_if.led, a_if.done_sig, a_if.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_down_multi();
        apply_reset();
        b_if.dir = 1'b1;
        for (int l = 0; l < 2; l++)
            for (int v = 15; v >= 0; v--) push_exp(v, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        for (int t = 1; exp_q.size() > 0; t++) begin
            if (t == 10) b_if.dir = 1'b0;
            run_tick(1'b1, t == 1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (b_if.led !== e.led || b_if.done_sig !== e.done || b_if.busy !== e.busy) begin
                failures++;
                $display("FAIL down_multi tick=%0d got led=%0d done=%b busy=%b required led=%0d done=%b busy=%b",
                         t, b_if.led, b_if.done_sig, b_if.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_pause();
        apply_reset();
        a_if.dir = 1'b0;
        for (int v = 0; v <= 5; v++) push_exp(v, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(5, 1'b0, 1'b1);
        for (int v = 6; v <= 15; v++) push_exp(v, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, t == 1, (t >= 7) && (t <= 9));
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.done_sig !== e.done || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL pause tick=%0d got led=%0d done=%b busy=%b required led=%0d done=%b busy=%b",
                         t, a_if.led, a_if.done_sig, a_if.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        a_if.dir = 1'b0;
        for (int v = 0; v <= 9; v++) push_exp(v, 1'b0, 1'b1);
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, t == 1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL mid_reset_run tick=%0d got led=%0d busy=%b required led=%0d busy=%b",
                         t, a_if.led, a_if.busy, e.led, e.busy);
            end
        end
        @(posedge clk);
        #2;
        rst_btn = 1'b0;
        #1;
        checks++;
        if (a_if.led !== 4'd0 || a_if.done_sig !== 1'b0 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abort got led=%0d done=%b busy=%b required 0/0/0", a_if.led, a_if.done_sig, a_if.busy);
        end
        repeat (2) @(negedge clk);
        rst_btn = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(0, 1'b0, 1'b0);
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.done_sig !== e.done || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL mid_reset_idle tick=%0d got led=%0d done=%b busy=%b required 0/0/0",
                         t, a_if.led, a_if.done_sig, a_if.busy);
            end
        end
    endtask

    task automatic test_ignored_go();
        apply_reset();
        a_if.dir = 1'b0;
        for (int v = 0; v <= 15; v++) push_exp(v, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
`ifdef FSM_AUTO_RESTART_EN
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
`else
        push_exp(0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b0);
`endif
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, (t == 1) || (t == 6) || (t == 18), 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.done_sig !== e.done || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL ignored_go tick=%0d got led=%0d done=%b busy=%b required led=%0d done=%b busy=%b",
                         t, a_if.led, a_if.done_sig, a_if.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    task automatic test_restart();
        apply_reset();
        a_if.dir = 1'b0;
        for (int v = 0; v <= 15; v++) push_exp(v, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
`ifdef FSM_AUTO_RESTART_EN
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
        push_exp(2, 1'b0, 1'b1);
`else
        push_exp(0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
`endif
        for (int t = 1; exp_q.size() > 0; t++) begin
            run_tick(1'b0, (t == 1) || ((t >= 17) && (t <= 19)), 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (a_if.led !== e.led || a_if.done_sig !== e.done || a_if.busy !== e.busy) begin
                failures++;
                $display("FAIL restart tick=%0d got led=%0d done=%b busy=%b required led=%0d done=%b busy=%b",
                         t, a_if.led, a_if.done_sig, a_if.busy, e.led, e.done, e.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_multi();
        test_pause();
        test_mid_reset();
        test_ignored_go();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsm_moore_seq_counter.md
Name: fsm_moore_seq_counter

Overview:
Parametrised successor to the button-driven Moore counter FSM. It derives a one-cycle tick enable from clk; there is no derived clock, so the whole block runs in the clk domain. On each tick it sequences a CNT_WIDTH-bit LED count up or down for N_LOOPS passes, with pause/resume. It asserts a Moore done flag for exactly one tick period and sits between board buttons and the LED bank.

Parameters:
CLK_DIV, 2000000, clk cycles per tick; must be ≥2.
CNT_WIDTH, 4, width of led.
MAX_COUNT, 15, terminal/start value; must be ≤ 2^CNT_WIDTH-1 and ≥1.
N_LOOPS, 1, full passes per run before DONE; must be ≥1.

Ports:
clk  input  1  system clock
rst_btn  input  1  asynchronous reset, active-low
go_btn  input  1  start request, active-low, asynchronous to clk
pause_btn  input  1  pause request, active-low, asynchronous to clk
dir  input  1  0 = count up (0→MAX_COUNT), 1 = count down (MAX_COUNT→0); static, sampled at start
led  output  CNT_WIDTH  current count
done_sig  output  1  high while in DONE
busy  output  1  high while in COUNTING or PAUSED

Behaviour:
- Reset (rst_btn low): immediate, regardless of clk. State=IDLE, led=0, done_sig=0, busy=0, divider=0, loop count=0, dir latch=0, synchronisers=0. Reset mid-run aborts the run; a new go is required after release.
- go_btn and pause_btn are inverted, then each passes through a 2-flop synchroniser: 2 clk latency.
- Tick generator: divider counts 0..CLK_DIV-1 (width $clog2(CLK_DIV)) and wraps. tick=1 for exactly one clk when divider==CLK_DIV-1. All state, led and loop updates occur only on clk edges where tick=1.
- Start value S = 0 if the dir latch is 0, otherwise MAX_COUNT. Terminal value T = MAX_COUNT if up, 0 if down.
- State IDLE: led=0. On tick with go=1: latch dir, led←S, loop←0, go to COUNTING. Otherwise stay.
- State COUNTING, on tick:
  - pause=1: go to PAUSED, led holds. Pause has priority over counting and terminal handling.
  - Else, led==T and loop==N_LOOPS-1: go to DONE, led←0.
  - Else, led==T: led←S, loop←loop+1.
  - Else: led←led+1 (up) or led−1 (down). There is no modular wrap; the terminal check always precedes the step.
- State PAUSED: led holds. On tick with pause=0, return to COUNTING. The step resumes on the following tick.
- State DONE: lasts exactly one tick. On tick go to IDLE. go is ignored here (see Optional Feature).
- go in COUNTING or PAUSED is ignored. dir changes mid-run are ignored.
- Outputs are Moore, decoded from registered state only: done_sig=(state==DONE); busy=(state==COUNTING or PAUSED).
- Unused state encodings recover to IDLE on the next tick.
- Per-run duration (no pause): N_LOOPS×(MAX_COUNT+1) ticks in COUNTING, plus 1 tick in DONE.

Optional Feature:
FSM_AUTO_RESTART_EN
- Defined: in DONE, on tick with go=1, go directly to COUNTING with led←S, loop←0, and dir re-latched. done_sig still stays high for one full tick period.
- Undefined: DONE always goes to IDLE, and go is ignored in DONE.

Test Plan:
- Reset: CLK_DIV=4. Pull rst_btn low between clk edges → led=0, done_sig=0, busy=0 immediately. Hold low 10 clk → tick never fires, outputs remain 0.
- Up run: CLK_DIV=4, CNT_WIDTH=4, MAX_COUNT=15, N_LOOPS=1, dir=0. Pulse go_btn low for 8 clk → led steps 0,1,…,15, one value per 4 clk, busy=1 throughout. Then done_sig=1 and led=0 for exactly 4 clk, then IDLE with done_sig=0 and busy=0.
- Down, multi-loop: N_LOOPS=2, dir=1 → led 15..0 twice with no gap (0 is followed by 15), done_sig pulses once, total 32 counting ticks.
- Pause: pause_btn held low while led=5 for 3 ticks → state PAUSED, led=5, busy=1, done_sig=0. Release → led=5 for one more tick, then 6.
- Mid-run reset and ignored go: assert reset at led=9 → led=0 and IDLE at once, and no count after release without a new go. Separately, toggle go during COUNTING and during DONE → no effect on the sequence.
- Macro: with FSM_AUTO_RESTART_EN and go held low through DONE → done_sig high 1 tick, then led=0 and busy=1 on the next tick without passing through IDLE. Without the macro → IDLE for at least 1 tick before the restart.
